bram_port_arbiter: RTL and testbench

// - Shares one two-port frame/sample BRAM (1 write port, 1 read port, 1-cycle registered read) between
//   two writers and two readers. Sits between the BRAM and its clients (scan-out reader, host/stream writers).
// - Write port: round-robin between W0 and W1. Read port: R0 fixed priority, R1 protected by a starvation limit.
// - Registers all BRAM-side controls; tags reads in flight and steers returned data to the owner.

---
 rtl/bram_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 27 ++
 rtl/bram_port_arbiter.sv | 130 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types and default widths for the BRAM port arbiter
package bram_arb_pkg;

  localparam int DEF_RAM_WIDTH     = 24;
  localparam int DEF_RAM_ADDR_BITS = 16;
  localparam int DEF_STARVE_LIMIT  = 8;

  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_t;

  typedef struct packed {
    logic    v;
    req_id_t id;
  } rd_tag_t;

  localparam rd_tag_t TAG_IDLE = '{v: 1'b0, id: REQ0};

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, pointer moves only on a grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // last_one set means requester 1 won most recently, so 0 is favoured next
  logic last_one;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_one ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_one <= 1'b1;
    end else if (|gnt) begin
      last_one <= gnt[1];
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - shares one 1W/1R BRAM between two writers and two readers
// Optional read-after-write bypass on same-cycle address collision: BRAM_ARB_BYPASS_EN
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
  parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
  parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     w0_req,
  input  logic [RAM_ADDR_BITS-1:0] w0_addr,
  input  logic [RAM_WIDTH-1:0]     w0_data,
  output logic                     w0_gnt,
  input  logic                     w1_req,
  input  logic [RAM_ADDR_BITS-1:0] w1_addr,
  input  logic [RAM_WIDTH-1:0]     w1_data,
  output logic                     w1_gnt,
  input  logic                     r0_req,
  input  logic [RAM_ADDR_BITS-1:0] r0_addr,
  output logic                     r0_gnt,
  output logic                     r0_valid,
  input  logic                     r1_req,
  input  logic [RAM_ADDR_BITS-1:0] r1_addr,
  output logic                     r1_gnt,
  output logic                     r1_valid,
  output logic [RAM_WIDTH-1:0]     rd_data,
  output logic                     bram_write,
  output logic [RAM_ADDR_BITS-1:0] bram_wa,
  output logic [RAM_WIDTH-1:0]     bram_data_in,
  output logic [RAM_ADDR_BITS-1:0] bram_ra,
  input  logic [RAM_WIDTH-1:0]     bram_data_out
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [1:0] wgnt;
  logic [7:0] starve_cnt;
  logic       r1_force;
  logic       rd_gnt;
  rd_tag_t    tag_s1;
  rd_tag_t    tag_s2;

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({w1_req, w0_req}),
    .gnt   (wgnt)
  );

  // Grants are held low while reset is asserted so no client sees a phantom handshake
  assign w0_gnt = rst_n & wgnt[0];
  assign w1_gnt = rst_n & wgnt[1];

  always_comb begin
    r1_force = (starve_cnt == LIMIT);
    r1_gnt   = rst_n & r1_req & (~r0_req | r1_force);
    r0_gnt   = rst_n & r0_req & ~r1_gnt;
    rd_gnt   = r0_gnt | r1_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!r1_req || r1_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_write   <= 1'b0;
      bram_wa      <= '0;
      bram_data_in <= '0;
    end else begin
      bram_write <= w0_gnt | w1_gnt;
      if (w0_gnt | w1_gnt) begin
        bram_wa      <= w1_gnt ? w1_addr : w0_addr;
        bram_data_in <= w1_gnt ? w1_data : w0_data;
      end
    end
  end

  // Stage 1 travels with bram_ra, stage 2 lines up with bram_data_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_ra <= '0;
      tag_s1  <= TAG_IDLE;
      tag_s2  <= TAG_IDLE;
    end else begin
      tag_s1 <= '{v: rd_gnt, id: (r1_gnt ? REQ1 : REQ0)};
      tag_s2 <= tag_s1;
      if (rd_gnt) begin
        bram_ra <= r1_gnt ? r1_addr : r0_addr;
      end
    end
  end

  assign r0_valid = tag_s2.v & (tag_s2.id == REQ0);
  assign r1_valid = tag_s2.v & (tag_s2.id == REQ1);

`ifdef BRAM_ARB_BYPASS_EN
  logic                 byp_hit;
  logic [RAM_WIDTH-1:0] byp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit <= tag_s1.v & bram_write & (bram_ra == bram_wa);
      if (tag_s1.v & bram_write & (bram_ra == bram_wa)) begin
        byp_data <= bram_data_in;
      end
    end
  end

  always_comb begin
    rd_data = byp_hit ? byp_data : bram_data_out;
  end
`else
  always_comb begin
    rd_data = bram_data_out;
  end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - scoreboard bench with a BRAM model and a rule-level reference model
module tb_bram_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 24;
  localparam int STARVE_LIMIT = 8;

  typedef struct {
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  logic          rq [4];
  logic [AW-1:0] ad [4];
  logic [DW-1:0] dt [4];
  int            prob [4];
  int            fixa [4];

  logic w0_gnt, w1_gnt, r0_gnt, r1_gnt, r0_valid, r1_valid, bram_write;
  logic [DW-1:0] rd_data, bram_data_in, bram_data_out;
  logic [AW-1:0] bram_wa, bram_ra;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bram_port_arbiter #(.RAM_WIDTH(DW), .RAM_ADDR_BITS(AW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .w0_req(rq[0]), .w0_addr(ad[0]), .w0_data(dt[0]), .w0_gnt(w0_gnt),
    .w1_req(rq[1]), .w1_addr(ad[1]), .w1_data(dt[1]), .w1_gnt(w1_gnt),
    .r0_req(rq[2]), .r0_addr(ad[2]), .r0_gnt(r0_gnt), .r0_valid(r0_valid),
    .r1_req(rq[3]), .r1_addr(ad[3]), .r1_gnt(r1_gnt), .r1_valid(r1_valid),
    .rd_data(rd_data), .bram_write(bram_write), .bram_wa(bram_wa),
    .bram_data_in(bram_data_in), .bram_ra(bram_ra), .bram_data_out(bram_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pattern(int a);
    return DW'((a * 32'h1357) ^ 32'hA5A5A5);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // BRAM: one write port, registered read returning the pre-write word on collision
  logic [DW-1:0] mem [int];
  initial begin
    logic [DW-1:0] rdv;
    bram_data_out = '0;
    forever begin
      @(posedge clk);
      rdv = mem.exists(int'(bram_ra)) ? mem[int'(bram_ra)] : pattern(int'(bram_ra));
      if (bram_write) mem[int'(bram_wa)] = bram_data_in;
      bram_data_out = rdv;
    end
  end

  // Reference model: grants from the arbitration rules, expected data from a shadow memory
  logic [DW-1:0] shadow [int];
  item_t wq[$], rdq0[$], rdq1[$];
  logic  m_gnt [4];
  int    m_last_w;
  int    m_starve;
  logic [AW-1:0] exp_ra;

  function automatic logic [DW-1:0] shrd(logic [AW-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : pattern(int'(a));
  endfunction

  always @(negedge clk) begin
    logic e_w0, e_w1, e_r0, e_r1, force_r1;
    logic [DW-1:0] rv;
    item_t it;
    if (!rst_n) begin
      wq.delete(); rdq0.delete(); rdq1.delete();
      m_last_w = 1; m_starve = 0; exp_ra = '0;
      for (int i = 0; i < 4; i++) m_gnt[i] = 1'b0;
      check("rst_gnt", {w0_gnt, w1_gnt, r0_gnt, r1_gnt}, 0);
    end else begin
      check("bram_ra", bram_ra, exp_ra);
      e_w0 = rq[0] && (!rq[1] || m_last_w == 1);
      e_w1 = rq[1] && !e_w0;
      force_r1 = (m_starve == STARVE_LIMIT);
      e_r1 = rq[3] && (!rq[2] || force_r1);
      e_r0 = rq[2] && !e_r1;
      if (rq[3] && !e_r1) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
      else m_starve = 0;
      check("wr_gnt", {w1_gnt, w0_gnt}, {e_w1, e_w0});
      check("rd_gnt", {r1_gnt, r0_gnt}, {e_r1, e_r0});
      m_gnt[0] = e_w0; m_gnt[1] = e_w1; m_gnt[2] = e_r0; m_gnt[3] = e_r1;
`ifndef BRAM_ARB_BYPASS_EN
      rv = e_r1 ? shrd(ad[3]) : shrd(ad[2]);
`endif
      if (e_w0 || e_w1) begin
        it.cyc = cyc + 1;
        it.a = e_w1 ? ad[1] : ad[0];
        it.d = e_w1 ? dt[1] : dt[0];
        wq.push_back(it);
        shadow[int'(it.a)] = it.d;
        m_last_w = e_w1 ? 1 : 0;
      end
`ifdef BRAM_ARB_BYPASS_EN
      rv = e_r1 ? shrd(ad[3]) : shrd(ad[2]);
`endif
      if (e_r0 || e_r1) begin
        it.cyc = cyc + 2;
        it.a = e_r1 ? ad[3] : ad[2];
        it.d = rv;
        if (e_r1) rdq1.push_back(it);
        else rdq0.push_back(it);
        exp_ra = it.a;
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT presents a write or a read result
  always @(negedge clk) begin
    item_t it;
    if (!rst_n) begin
      check("rst_out", {bram_write, r0_valid, r1_valid, bram_wa, bram_ra, bram_data_in}, 0);
    end else begin
      if (bram_write) begin
        if (wq.size() == 0) check("wr_spurious", bram_write, 0);
        else begin
          it = wq.pop_front();
          check("wr_cyc", cyc, it.cyc);
          check("wr_addr", bram_wa, it.a);
          check("wr_data", bram_data_in, it.d);
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        it = wq.pop_front();
        check("wr_missing", bram_write, 1);
      end
      if (r0_valid) begin
        if (rdq0.size() == 0) check("r0_spurious", r0_valid, 0);
        else begin
          it = rdq0.pop_front();
          check("r0_cyc", cyc, it.cyc);
          check("r0_data", rd_data, it.d);
        end
      end else if (rdq0.size() > 0 && rdq0[0].cyc <= cyc) begin
        it = rdq0.pop_front();
        check("r0_missing", r0_valid, 1);
      end
      if (r1_valid) begin
        if (rdq1.size() == 0) check("r1_spurious", r1_valid, 0);
        else begin
          it = rdq1.pop_front();
          check("r1_cyc", cyc, it.cyc);
          check("r1_data", rd_data, it.d);
        end
      end else if (rdq1.size() > 0 && rdq1[0].cyc <= cyc) begin
        it = rdq1.pop_front();
        check("r1_missing", r1_valid, 1);
      end
    end
  end

  // Requests are held until the reference model says they were granted
  task automatic drive();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (!rq[i] || m_gnt[i]) begin
        rq[i] = ($urandom_range(0, 99) < prob[i]);
        ad[i] = (fixa[i] >= 0) ? AW'(fixa[i]) : AW'($urandom_range(0, 15));
        dt[i] = DW'($urandom);
      end
    end
  endtask

  task automatic set_prob(int p0, int p1, int p2, int p3);
    prob[0] = p0; prob[1] = p1; prob[2] = p2; prob[3] = p3;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, vcount;
    logic seen;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rq[i] = 1'b0; ad[i] = '0; dt[i] = '0; prob[i] = 0; fixa[i] = -1;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Both writers requesting: W0 first after reset, then strict alternation
    fixa[0] = 16'h10; fixa[1] = 16'h20;
    set_prob(100, 100, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive();
      @(negedge clk); #1;
      check("w_alt", {w1_gnt, w0_gnt}, (k % 2 == 1) ? 2'b10 : 2'b01);
    end
    set_prob(0, 0, 0, 0);
    fixa[0] = -1; fixa[1] = -1;
    repeat (4) drive();

    // Back-to-back R0 reads give four consecutive results
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      rq[2] = (i < 4); ad[2] = AW'(i);
      @(negedge clk); #1;
      if (r0_valid) vcount++;
    end
    check("b2b_cnt", vcount, 4);
    repeat (2) drive();

    // Write and read of the same address land in the same BRAM cycle
    @(posedge clk); #1;
    rq[0] = 1'b1; ad[0] = 16'h0005; dt[0] = 24'h00ABCD;
    rq[2] = 1'b1; ad[2] = 16'h0005;
    @(posedge clk); #1;
    rq[0] = 1'b0; rq[2] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk); #1;
      if (r0_valid) begin
        seen = 1'b1;
`ifdef BRAM_ARB_BYPASS_EN
        check("collide_data", rd_data, 24'h00ABCD);
`else
        check("collide_data", rd_data, pattern(5));
`endif
      end
    end
    check("collide_seen", seen, 1);
    repeat (2) drive();

    // W1 and R1 granted in the same cycle
    @(posedge clk); #1;
    rq[1] = 1'b1; ad[1] = 16'h0007; dt[1] = DW'($urandom);
    rq[3] = 1'b1; ad[3] = 16'h0007;
    @(negedge clk); #1;
    check("w1r1_gnt", {w1_gnt, r1_gnt}, 2'b11);
    @(posedge clk); #1;
    rq[1] = 1'b0; rq[3] = 1'b0;
    repeat (3) drive();

    // R0 hogs the read port; R1 must win on its ninth requesting cycle
    fixa[3] = 16'h0042;
    set_prob(0, 0, 100, 100);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      drive();
      @(negedge clk); #1;
      n++;
      if (r1_gnt) break;
    end
    check("starve_cycles", n, STARVE_LIMIT + 1);
    prob[3] = 0;
    drive(); @(negedge clk); #1;
    drive(); @(negedge clk); #1;
    check("starve_r1_valid", r1_valid, 1);
    check("starve_r1_data", rd_data, pattern(16'h0042));
    fixa[3] = -1;
    set_prob(0, 0, 0, 0);
    repeat (4) drive();

    // Reset while reads are in flight
    set_prob(0, 0, 100, 60);
    repeat (3) drive();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) rq[i] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check("post_rst_valid", {r0_valid, r1_valid}, 2'b00);
    end

    // Random traffic on all four clients over a small address window
    set_prob(60, 60, 60, 60);
    repeat (400) drive();
    set_prob(0, 0, 0, 0);
    repeat (10) drive();
    check("drain", wq.size() + rdq0.size() + rdq1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
